// File: rtl/rx_pkt_payload_q_enqueue.sv
// rx_pkt_payload_q_enqueue
//   Three-stage enqueue pipeline for per-flow RX payload ring queues.
//   QP issues head/tail pointer reads, W checks fullness and writes the entry
//   and the advanced tail, O holds the enqueue result for the consumer.
// Ports
//   clk, rst                       : clock, synchronous active-low reset
//   write_payload_req_*            : enqueue request (val/rdy, flowid, entry)
//   write_payload_resp_*           : enqueue result (val/rdy, is_full)
//   enqueue_{head,tail}_ptr_mem_*  : pointer memory read request/response
//   enqueue_tail_ptr_mem_wr_req_*  : tail pointer update
//   enqueue_payload_buffer_wr_req_*: payload entry write
// Widths mirror state_defs.vh; PAYLOAD_BUF_MEM_ADDR_W = FLOW_ID_W + RX_PAYLOAD_Q_SIZE_W.
module rx_pkt_payload_q_enqueue #(
  parameter int unsigned FLOW_ID_W              = 4,
  parameter int unsigned RX_PAYLOAD_Q_SIZE_W    = 4,
  parameter int unsigned PAYLOAD_ENTRY_W        = 8,
  parameter int unsigned PAYLOAD_BUF_MEM_ADDR_W = FLOW_ID_W + RX_PAYLOAD_Q_SIZE_W
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic                              write_payload_req_val,
  input  logic [FLOW_ID_W-1:0]              write_payload_req_flowid,
  input  logic [PAYLOAD_ENTRY_W-1:0]        write_payload_req_entry,
  output logic                              write_payload_req_rdy,

  output logic                              write_payload_resp_val,
  output logic                              write_payload_resp_is_full,
  input  logic                              write_payload_resp_rdy,

  output logic                              enqueue_head_ptr_mem_rd_req_val,
  output logic [FLOW_ID_W-1:0]              enqueue_head_ptr_mem_rd_req_addr,
  input  logic                              head_ptr_mem_enqueue_rd_req_rdy,
  input  logic                              head_ptr_mem_enqueue_rd_resp_val,
  input  logic [RX_PAYLOAD_Q_SIZE_W:0]      head_ptr_mem_enqueue_rd_resp_data,
  output logic                              enqueue_head_ptr_mem_rd_resp_rdy,

  output logic                              enqueue_tail_ptr_mem_rd_req_val,
  output logic [FLOW_ID_W-1:0]              enqueue_tail_ptr_mem_rd_req_addr,
  input  logic                              tail_ptr_mem_enqueue_rd_req_rdy,
  input  logic                              tail_ptr_mem_enqueue_rd_resp_val,
  input  logic [RX_PAYLOAD_Q_SIZE_W:0]      tail_ptr_mem_enqueue_rd_resp_data,
  output logic                              enqueue_tail_ptr_mem_rd_resp_rdy,

  output logic                              enqueue_tail_ptr_mem_wr_req_val,
  output logic [FLOW_ID_W-1:0]              enqueue_tail_ptr_mem_wr_req_addr,
  output logic [RX_PAYLOAD_Q_SIZE_W:0]      enqueue_tail_ptr_mem_wr_req_data,
  input  logic                              tail_ptr_mem_enqueue_wr_req_rdy,

  output logic                              enqueue_payload_buffer_wr_req_val,
  output logic [PAYLOAD_BUF_MEM_ADDR_W-1:0] enqueue_payload_buffer_wr_req_addr,
  output logic [PAYLOAD_ENTRY_W-1:0]        enqueue_payload_buffer_wr_req_data,
  input  logic                              payload_buffer_enqueue_wr_req_rdy
);

  // Pointer width: slot index plus one wrap bit to tell full from empty.
  localparam int unsigned PTR_W = RX_PAYLOAD_Q_SIZE_W + 1;

  // Stage registers
  logic                       val_w;
  logic [FLOW_ID_W-1:0]       flowid_w;
  logic [PAYLOAD_ENTRY_W-1:0] entry_w;
  logic                       val_o;
  logic                       is_full_o;

  // Tail forwarding register: most recent tail written by this block
  logic                       fwd_val;
  logic [FLOW_ID_W-1:0]       fwd_flowid;
  logic [PTR_W-1:0]           fwd_tail;

  logic                       stall_qp;
  logic                       stall_w;
  logic                       stall_o;
  logic                       fwd_hit;
  logic [PTR_W-1:0]           eff_tail;
  logic [PTR_W-1:0]           tail_inc;
  logic                       full;
  logic                       go_w;
  logic                       do_write;

  // QP: pointer reads track the incoming request directly
  assign enqueue_head_ptr_mem_rd_req_val  = write_payload_req_val;
  assign enqueue_head_ptr_mem_rd_req_addr = write_payload_req_flowid;
  assign enqueue_tail_ptr_mem_rd_req_val  = write_payload_req_val;
  assign enqueue_tail_ptr_mem_rd_req_addr = write_payload_req_flowid;

  assign stall_qp = write_payload_req_val &
                    (stall_w | ~head_ptr_mem_enqueue_rd_req_rdy | ~tail_ptr_mem_enqueue_rd_req_rdy);
  assign write_payload_req_rdy = ~stall_qp;

  // W: the forwarded tail wins over a memory read that may predate our last write
  assign fwd_hit  = fwd_val & (fwd_flowid == flowid_w);
  assign eff_tail = fwd_hit ? fwd_tail : tail_ptr_mem_enqueue_rd_resp_data;
  assign tail_inc = eff_tail + PTR_W'(1);

  // Full: same slot index, opposite wrap bit. A stale head only errs toward full.
  assign full = (head_ptr_mem_enqueue_rd_resp_data[PTR_W-1] != eff_tail[PTR_W-1]) &
                (head_ptr_mem_enqueue_rd_resp_data[PTR_W-2:0] == eff_tail[PTR_W-2:0]);

  assign stall_o = val_o & ~write_payload_resp_rdy;
  assign stall_w = val_w & (stall_o |
                            ~head_ptr_mem_enqueue_rd_resp_val |
                            ~tail_ptr_mem_enqueue_rd_resp_val |
                            (~full & (~payload_buffer_enqueue_wr_req_rdy |
                                      ~tail_ptr_mem_enqueue_wr_req_rdy)));

  // Reset gates all side effects of the entry currently sitting in W
  assign go_w     = val_w & rst & ~stall_w;
  assign do_write = go_w & ~full;

  assign enqueue_head_ptr_mem_rd_resp_rdy = go_w;
  assign enqueue_tail_ptr_mem_rd_resp_rdy = go_w;

  // Payload and tail writes always issue as a pair
  assign enqueue_payload_buffer_wr_req_val  = do_write;
  assign enqueue_payload_buffer_wr_req_addr = {flowid_w, eff_tail[PTR_W-2:0]};
  assign enqueue_payload_buffer_wr_req_data = entry_w;
  assign enqueue_tail_ptr_mem_wr_req_val    = do_write;
  assign enqueue_tail_ptr_mem_wr_req_addr   = flowid_w;
  assign enqueue_tail_ptr_mem_wr_req_data   = tail_inc;

  // O: result presentation
  assign write_payload_resp_val     = val_o & rst;
  assign write_payload_resp_is_full = is_full_o;

  // Control registers; a stalled stage hands a bubble downstream
  always_ff @(posedge clk) begin
    if (!rst) begin
      val_w     <= 1'b0;
      val_o     <= 1'b0;
      is_full_o <= 1'b0;
      fwd_val   <= 1'b0;
    end else begin
      if (!stall_w) val_w <= write_payload_req_val & ~stall_qp;
      if (!stall_o) val_o <= val_w & ~stall_w;
      if (go_w)     is_full_o <= full;
      if (do_write) fwd_val <= 1'b1;
    end
  end

  // Datapath registers, qualified by the valid bits above
  always_ff @(posedge clk) begin
    if (!stall_w) begin
      flowid_w <= write_payload_req_flowid;
      entry_w  <= write_payload_req_entry;
    end
    if (do_write) begin
      fwd_flowid <= flowid_w;
      fwd_tail   <= tail_inc;
    end
  end

endmodule
